// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: steers big-endian byte lanes onto the data RAM port,
// holds each access for a programmable number of wait cycles and returns an extended load result.
module mem_access_unit #(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall_req,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        excp_misalign,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       op_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             misalign_q;

  logic             op_ok;
  logic             req_misalign;
  logic             accept;
  logic             last_access;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_val;

  assign op_ok       = (req_op >= OP_LB) && (req_op <= OP_SW);
  assign accept      = (state == S_IDLE) && req_valid && op_ok;
  assign last_access = (state == S_ACCESS) && (wait_cnt == WAIT_LAST);

  always_comb begin
    req_misalign = 1'b0;
    case (req_op)
      OP_LH, OP_LHU, OP_SH: req_misalign = req_addr[0];
      OP_LW, OP_SW:         req_misalign = (req_addr[1:0] != 2'b00);
      default:              req_misalign = 1'b0;
    endcase
  end

  // Big-endian lane pick: byte offset 0 lives in bits 31:24.
  always_comb begin
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_byte = ram_rdata[31:24];
      2'd1:    lane_byte = ram_rdata[23:16];
      2'd2:    lane_byte = ram_rdata[15:8];
      default: lane_byte = ram_rdata[7:0];
    endcase
    lane_half = addr_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    load_val  = 32'h0;
    case (op_q)
      OP_LB:   load_val = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_val = {24'h0, lane_byte};
      OP_LH:   load_val = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_val = {16'h0, lane_half};
      OP_LW:   load_val = ram_rdata;
      default: load_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      op_q       <= 4'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q       <= req_op;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            wait_cnt   <= '0;
            rdata_q    <= 32'h0;
            misalign_q <= req_misalign;
            state      <= req_misalign ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (last_access) begin
            rdata_q <= load_val;
            state   <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM port is quiet outside ACCESS so an aborted or misaligned op never touches memory.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_sel   = 4'b0000;
    ram_addr  = 32'h0;
    ram_wdata = 32'h0;
    if (state == S_ACCESS) begin
      ram_ce   = 1'b1;
      ram_we   = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
      ram_addr = {addr_q[31:2], 2'b00};
      case (op_q)
        OP_LB, OP_LBU, OP_SB: ram_sel = 4'b1000 >> addr_q[1:0];
        OP_LH, OP_LHU, OP_SH: ram_sel = addr_q[1] ? 4'b0011 : 4'b1100;
        default:              ram_sel = 4'b1111;
      endcase
      case (op_q)
        OP_SB:   ram_wdata = {4{wdata_q[7:0]}};
        OP_SH:   ram_wdata = {2{wdata_q[15:0]}};
        OP_SW:   ram_wdata = wdata_q;
        default: ram_wdata = 32'h0;
      endcase
    end
  end

  assign req_ready     = (state == S_IDLE);
  assign stall_req     = accept || (state == S_ACCESS);
  assign resp_valid    = (state == S_RESP);
  assign resp_rdata    = resp_valid ? rdata_q : 32'h0;
  assign excp_misalign = resp_valid && misalign_q;

endmodule
